// File: rtl/cam_rx_pkg.sv
// Shared types and defaults for the camera bit-stream receiver.
package cam_rx_pkg;

  localparam int unsigned CAM_FRAME_BITS = 15440;
  localparam int unsigned CAM_WORD_W     = 16;

  typedef enum logic [1:0] {
    CAM_IDLE = 2'd0,
    CAM_ARM  = 2'd1,
    CAM_RECV = 2'd2
  } cam_state_e;

  // Number of (possibly partial) words needed to carry one frame.
  function automatic int unsigned words_per_frame(input int unsigned frame_bits,
                                                  input int unsigned word_w);
    return (frame_bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cam_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a same-cycle push.
module cam_rx_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == OCC_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_bit_rx.sv
// Camera bit-stream receiver: requests a frame, packs bits MSB-first into words, buffers them.
module cam_bit_rx
  import cam_rx_pkg::*;
#(
  parameter int unsigned FRAME_BITS = CAM_FRAME_BITS,
  parameter int unsigned WORD_W     = CAM_WORD_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_cam_data,
  output logic              o_asl_ready,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word_data,
  output logic              o_word_last,
  input  logic              i_word_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_ovf,
  input  logic              i_ovf_clr
);

  localparam logic [1:0]  S_IDLE = CAM_IDLE;
  localparam logic [1:0]  S_ARM  = CAM_ARM;
  localparam logic [1:0]  S_RECV = CAM_RECV;
  localparam int unsigned FILL_W = $clog2(WORD_W);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              asl_q, asl_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic              push;
  logic [WORD_W:0]   push_data;
  logic [WORD_W-1:0] shifted;
  logic              last_bit;
  logic              word_end;
  logic              drop;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W:0]   fifo_rd;

  assign fifo_pop = !fifo_empty && i_word_ready;

  // Next-state, packing and overflow logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    shift_d   = shift_q;
    asl_d     = asl_q;
    done_d    = 1'b0;
    push      = 1'b0;
    shifted   = {shift_q[WORD_W-2:0], i_cam_data};
    last_bit  = (cnt_q == CNT_W'(FRAME_BITS - 1));
    word_end  = (fill_q == FILL_W'(WORD_W - 1)) || last_bit;
    // Left-align a short final word; a full word shifts by zero.
    push_data = {last_bit, shifted << (FILL_W'(WORD_W - 1) - fill_q)};
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ARM;
          asl_d   = 1'b1;
          cnt_d   = '0;
          fill_d  = '0;
          shift_d = '0;
        end
      end
      S_ARM: begin
        state_d = S_RECV;
      end
      S_RECV: begin
        shift_d = shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        fill_d  = fill_q + FILL_W'(1);
        if (word_end) begin
          push    = 1'b1;
          fill_d  = '0;
          shift_d = '0;
        end
        if (last_bit) begin
          state_d = S_IDLE;
          asl_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        asl_d   = 1'b0;
      end
    endcase
    drop   = push && fifo_full && !fifo_pop;
    ovf_d  = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      shift_q <= '0;
      asl_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      shift_q <= shift_d;
      asl_q   <= asl_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  cam_rx_fifo #(
    .WIDTH(WORD_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (fifo_pop),
    .pop_data (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign o_asl_ready  = asl_q;
  assign o_frame_done = done_q;
  assign o_ovf        = ovf_q;
  assign o_busy       = busy_q;
  assign o_word_valid = !fifo_empty;
  assign o_word_data  = fifo_empty ? '0 : fifo_rd[WORD_W-1:0];
  assign o_word_last  = !fifo_empty && fifo_rd[WORD_W];

endmodule

// File: tb/tb_cam_bit_rx.sv
// Bench for cam_bit_rx: source model, word scoreboard and per-scenario tasks.
module tb_cam_bit_rx;

  localparam int unsigned FB    = 15440;
  localparam int unsigned WW    = 16;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cam_data;
  logic          asl_ready;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_last;
  logic          word_ready = 1'b1;
  logic          busy;
  logic          frame_done;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  logic          s_start = 1'b0;
  logic          s_asl_ready;
  logic          s_valid;
  logic [WW-1:0] s_data;
  logic          s_last;
  logic          s_busy;
  logic          s_done;
  logic          s_ovf;

  cam_bit_rx dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_cam_data(cam_data),
    .o_asl_ready(asl_ready), .o_word_valid(word_valid), .o_word_data(word_data),
    .o_word_last(word_last), .i_word_ready(word_ready), .o_busy(busy),
    .o_frame_done(frame_done), .o_ovf(ovf), .i_ovf_clr(ovf_clr)
  );

  cam_bit_rx #(.FRAME_BITS(40), .WORD_W(16), .FIFO_DEPTH(8), .CNT_W(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_cam_data(1'b1),
    .o_asl_ready(s_asl_ready), .o_word_valid(s_valid), .o_word_data(s_data),
    .o_word_last(s_last), .i_word_ready(1'b1), .o_busy(s_busy),
    .o_frame_done(s_done), .o_ovf(s_ovf), .i_ovf_clr(1'b0)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Camera source: loads index 0 on the first edge it sees the request, then advances.
  int unsigned idx   = 0;
  logic        rdy_d = 1'b0;
  int unsigned pat   = 0;
  always @(posedge clk) begin
    rdy_d <= asl_ready;
    if (asl_ready) idx <= rdy_d ? ((idx == FB - 1) ? 0 : idx + 1) : 0;
  end
  assign cam_data = rdy_d ? ((pat == 0) ? 1'b1 : idx[0]) : 1'b0;

  // Scoreboard model of packing, FIFO occupancy, overflow and frame_done.
  logic [WW:0]   sb[$];
  logic [WW-1:0] acc = '0;
  logic [WW-1:0] w;
  logic [WW:0]   exp_w;
  int            fill = 0;
  logic          exp_ovf = 1'b0;
  logic          exp_done = 1'b0;
  logic          set_ovf;
  int            pops = 0;
  int            dones = 0;
  int            drops = 0;
  int            first_drop = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      acc = '0; fill = 0; exp_ovf = 1'b0; exp_done = 1'b0;
    end else begin
      vectors++;
      if (word_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL word_valid: got %b expected %b", word_valid, sb.size() != 0);
      end
      vectors++;
      if (ovf !== exp_ovf) begin
        miscompares++;
        $display("FAIL ovf: got %b expected %b (idx %0d)", ovf, exp_ovf, idx);
      end
      vectors++;
      if (frame_done !== exp_done) begin
        miscompares++;
        $display("FAIL frame_done: got %b expected %b", frame_done, exp_done);
      end
      if (frame_done) dones++;
      exp_done = 1'b0;
      if (sb.size() != 0 && word_ready) begin
        exp_w = sb.pop_front();
        vectors++;
        if ({word_last, word_data} !== exp_w) begin
          miscompares++;
          $display("FAIL word %0d: got last=%b data=%h expected last=%b data=%h",
                   pops, word_last, word_data, exp_w[WW], exp_w[WW-1:0]);
        end
        pops++;
      end
      set_ovf = 1'b0;
      if (asl_ready && rdy_d) begin
        acc = {acc[WW-2:0], cam_data};
        fill++;
        if (fill == WW || idx == FB - 1) begin
          w = acc << (WW - fill);
          if (sb.size() < DEPTH) sb.push_back({idx == FB - 1, w});
          else begin
            set_ovf = 1'b1;
            drops++;
            if (first_drop < 0) first_drop = int'(idx);
          end
          acc = '0;
          fill = 0;
        end
        if (idx == FB - 1) exp_done = 1'b1;
      end
      if (set_ovf) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    pops = 0; dones = 0; drops = 0; first_drop = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin step(); n++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({asl_ready, word_valid, word_data, word_last, busy, frame_done, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h l=%b busy=%b done=%b ovf=%b required all 0",
               asl_ready, word_valid, word_data, word_last, busy, frame_done, ovf);
    end
    vectors++;
    if ({s_asl_ready, s_valid, s_data, s_last, s_busy, s_done, s_ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_short: got nonzero outputs, required all 0");
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_all_ones();
    int hi = 0;
    pat = 0; word_ready = 1'b1; clear_counts();
    pulse_start();
    while (asl_ready && hi < 20000) begin hi++; step(); end
    vectors++;
    if (hi != 15441) begin
      miscompares++;
      $display("FAIL asl_ready_width: got %0d cycles required 15441", hi);
    end
    wait_idle("all_ones");
    vectors++;
    if (pops != 965 || dones != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL all_ones_counts: got words=%0d done=%0d left=%0d required 965/1/0",
               pops, dones, sb.size());
    end
  endtask

  task automatic test_short_frame();
    logic [WW:0] q[$];
    int got = 0;
    int dn  = 0;
    q.push_back({1'b0, 16'hFFFF});
    q.push_back({1'b0, 16'hFFFF});
    q.push_back({1'b1, 16'hFF00});
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (s_done) dn++;
      if (s_valid) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL short_extra_word: got data=%h required no word", s_data);
        end else begin
          exp_w = q.pop_front();
          vectors++;
          if ({s_last, s_data} !== exp_w) begin
            miscompares++;
            $display("FAIL short_word %0d: got last=%b data=%h required last=%b data=%h",
                     got, s_last, s_data, exp_w[WW], exp_w[WW-1:0]);
          end
          got++;
        end
      end
      step();
    end
    vectors++;
    if (got != 3 || dn != 1 || s_asl_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL short_counts: got words=%0d done=%0d rdy=%b required 3/1/0",
               got, dn, s_asl_ready);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    pat = 0; word_ready = 1'b0; clear_counts();
    pulse_start();
    while (!(rdy_d && idx == 165) && n < 20000) begin step(); n++; end
    vectors++;
    if (ovf !== 1'b1 || first_drop != 143) begin
      miscompares++;
      $display("FAIL ovf_first: got ovf=%b first_drop_bit=%0d required 1/143", ovf, first_drop);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b required 0", ovf);
    end
    while (!(rdy_d && idx == 207) && n < 20000) begin step(); n++; end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_over_clr: got %b required 1", ovf);
    end
    wait_idle("overflow");
    vectors++;
    if (drops != 957 || sb.size() != DEPTH || ovf !== 1'b1 || dones != 1) begin
      miscompares++;
      $display("FAIL ovf_frame: got drops=%0d held=%0d ovf=%b done=%0d required 957/8/1/1",
               drops, sb.size(), ovf, dones);
    end
    pops = 0;
    word_ready = 1'b1;
    n = 0;
    while ((word_valid || sb.size() != 0) && n < 50) begin step(); n++; end
    repeat (2) step();
    vectors++;
    if (pops != DEPTH || word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drain: got words=%0d valid=%b required 8/0", pops, word_valid);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_final_clear: got %b required 0", ovf);
    end
  endtask

  task automatic test_reset_mid_recv();
    int n = 0;
    pat = 1; word_ready = 1'b1; clear_counts();
    pulse_start();
    while (!(rdy_d && idx == 1000) && n < 5000) begin step(); n++; end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (asl_ready !== 1'b0 || word_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b valid=%b busy=%b required 0/0/0",
               asl_ready, word_valid, busy);
    end
    step();
  endtask

  task automatic test_alt_pattern_restart();
    int c = 0;
    pat = 1; word_ready = 1'b1; clear_counts();
    pulse_start();
    vectors++;
    if (asl_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL asl_rise: got %b required 1", asl_ready);
    end
    while (!word_valid && c < 100) begin step(); c++; end
    vectors++;
    if (c != 17) begin
      miscompares++;
      $display("FAIL first_word_latency: got %0d cycles required 17", c);
    end
    c = 0;
    while (!(rdy_d && idx == 3000) && c < 20000) begin step(); c++; end
    pulse_start();
    while (!(rdy_d && idx == FB - 1) && c < 20000) begin step(); c++; end
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (asl_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL restart_ignored %0d: got rdy=%b busy=%b required 0/0", k, asl_ready, busy);
      end
      step();
    end
    vectors++;
    if (pops != 965 || dones != 1) begin
      miscompares++;
      $display("FAIL alt_counts: got words=%0d done=%0d required 965/1", pops, dones);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_short_frame();
    test_overflow();
    test_reset_mid_recv();
    test_alt_pattern_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
